// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT/INTT address generator: FSM states, mode codes
// and the stage-counter width helper.
package ntt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } ntt_state_e;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Bits needed to hold a stage index 0..logn-1.
    function automatic int unsigned stage_w(input int unsigned logn);
        return (logn < 3) ? 1 : $clog2(logn);
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth register chain with synchronous active-low clear.
module ntt_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_addrgen_p.sv
// Radix-2 NTT/INTT butterfly address generator: read pairs and twiddle address per
// stage, write-back addresses after the read + butterfly latency, ping-pong banks.
module ntt_addrgen_p
    import ntt_pkg::*;
#(
    parameter int unsigned LOGN    = 8,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned BFU_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        mode,
    input  logic                        valid,
    output logic                        busy,
    output logic                        done,
    output logic [stage_w(LOGN)-1:0]    stage,
    output logic                        rd_en,
    output logic                        rd_bank,
    output logic [LOGN-1:0]             rd_addr_0,
    output logic [LOGN-1:0]             rd_addr_1,
    output logic [LOGN-1:0]             rom_addr,
    output logic                        bfu_en,
    output logic                        wr_en,
    output logic                        wr_bank,
    output logic [LOGN-1:0]             wr_addr_0,
    output logic [LOGN-1:0]             wr_addr_1,
    output logic                        res_bank
);

    localparam int unsigned N   = 1 << LOGN;
    localparam int unsigned P   = RD_LAT + BFU_LAT;
    localparam int unsigned SW  = stage_w(LOGN);
    localparam int unsigned KW  = LOGN - 1;
    localparam int unsigned DW  = $clog2(P + 1);
    localparam int unsigned WRW = 1 + 2 * LOGN;

    ntt_state_e      state;
    logic [KW-1:0]   k;
    logic [SW-1:0]   scnt;
    logic [DW-1:0]   dcnt;
    logic            mode_r;

    logic [SW-1:0]   sh_c;
    logic [LOGN-1:0] k_c;
    logic [LOGN-1:0] one_h_c;
    logic [LOGN-1:0] mask_c;
    logic [LOGN-1:0] off_c;
    logic [LOGN-1:0] addr0_c;
    logic [LOGN-1:0] addr1_c;
    logic [LOGN-1:0] rom_c;

    // Butterfly span h is a power of two, so k mod h / k div h reduce to masking.
    always_comb begin
        sh_c    = (mode_r == MODE_INV) ? scnt : (SW'(LOGN - 1) - scnt);
        k_c     = LOGN'(k);
        one_h_c = LOGN'(1) << sh_c;
        mask_c  = one_h_c - LOGN'(1);
        off_c   = k_c & mask_c;
        addr0_c = ((k_c & ~mask_c) << 1) | off_c;
        addr1_c = addr0_c | one_h_c;
        if (mode_r == MODE_INV) begin
            rom_c = LOGN'(N / 2) | (off_c << (SW'(LOGN - 1) - scnt));
        end else begin
            rom_c = off_c << scnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k         <= '0;
            scnt      <= '0;
            dcnt      <= '0;
            mode_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_bank   <= 1'b0;
            wr_bank   <= 1'b0;
            rd_addr_0 <= '0;
            rd_addr_1 <= '0;
            rom_addr  <= '0;
            res_bank  <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_WAIT;
                        busy     <= 1'b1;
                        mode_r   <= mode;
                        k        <= '0;
                        scnt     <= '0;
                        dcnt     <= '0;
                        stage    <= '0;
                        rd_bank  <= 1'b0;
                        wr_bank  <= 1'b1;
                        res_bank <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (valid) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (valid) begin
                        rd_en     <= 1'b1;
                        rd_addr_0 <= addr0_c;
                        rd_addr_1 <= addr1_c;
                        rom_addr  <= rom_c;
                        // Stage and banks follow the issued reads so the drain keeps the old set.
                        stage     <= scnt;
                        rd_bank   <= scnt[0];
                        wr_bank   <= ~scnt[0];
                        if (k == KW'(N / 2 - 1)) begin
                            k     <= '0;
                            dcnt  <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DW'(P - 1)) begin
                        dcnt <= '0;
                        if (scnt == SW'(LOGN - 1)) begin
                            state <= ST_FIN;
                        end else begin
                            scnt  <= scnt + SW'(1);
                            state <= ST_RUN;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                ST_FIN: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    res_bank <= 1'(LOGN % 2);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ntt_delay_line #(
        .DEPTH (RD_LAT),
        .W     (1)
    ) u_bfu_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rd_en),
        .q     (bfu_en)
    );

    logic [WRW-1:0] wr_q;

    // Write strobe and addresses are the read side replayed P cycles later.
    ntt_delay_line #(
        .DEPTH (P),
        .W     (WRW)
    ) u_wr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({rd_en, rd_addr_0, rd_addr_1}),
        .q     (wr_q)
    );

    assign {wr_en, wr_addr_0, wr_addr_1} = wr_q;

endmodule

// File: tb/tb_ntt_addrgen_p.sv
// Directed bench for ntt_addrgen_p: LOGN=3 forward/inverse/stall/restart/reset
// scenarios against hand-computed tables, plus a LOGN=8 full-length run.
module tb_ntt_addrgen_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, mode, valid;
    logic start_8, mode_8, valid_8;

    logic       busy, done, rd_en, rd_bank, bfu_en, wr_en, wr_bank, res_bank;
    logic [1:0] stage;
    logic [2:0] rd_addr_0, rd_addr_1, rom_addr, wr_addr_0, wr_addr_1;

    logic       busy_8, done_8, rd_en_8, rd_bank_8, bfu_en_8, wr_en_8, wr_bank_8, res_bank_8;
    logic [2:0] stage_8;
    logic [7:0] rd_addr_0_8, rd_addr_1_8, rom_addr_8, wr_addr_0_8, wr_addr_1_8;

    ntt_addrgen_p #(.LOGN(3), .RD_LAT(1), .BFU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .valid(valid),
        .busy(busy), .done(done), .stage(stage), .rd_en(rd_en), .rd_bank(rd_bank),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rom_addr(rom_addr),
        .bfu_en(bfu_en), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1), .res_bank(res_bank)
    );

    ntt_addrgen_p #(.LOGN(8), .RD_LAT(2), .BFU_LAT(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_8), .mode(mode_8), .valid(valid_8),
        .busy(busy_8), .done(done_8), .stage(stage_8), .rd_en(rd_en_8), .rd_bank(rd_bank_8),
        .rd_addr_0(rd_addr_0_8), .rd_addr_1(rd_addr_1_8), .rom_addr(rom_addr_8),
        .bfu_en(bfu_en_8), .wr_en(wr_en_8), .wr_bank(wr_bank_8),
        .wr_addr_0(wr_addr_0_8), .wr_addr_1(wr_addr_1_8), .res_bank(res_bank_8)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Hand-derived butterfly tables for N=8, indexed stage*4 + k.
    int f_a0  [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int f_a1  [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int f_rom [12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};
    int i_a0  [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int i_a1  [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int i_rom [12] = '{4,4,4,4, 4,6,4,6, 4,5,6,7};

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input bit exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Table index of the read expected in relative cycle t (stage period 7), or -1.
    function automatic int ridx(input int t, input bit stall);
        int tt;
        tt = t;
        if (stall) begin
            if (t >= 9 && t < 14) return -1;
            if (t >= 14) tt = t - 5;
        end
        if (tt < 0 || tt >= 21) return -1;
        if (tt % 7 >= 4) return -1;
        return (tt / 7) * 4 + tt % 7;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_rd_en"}, rd_en, 1'b0);
        chk1({tag, "_bfu_en"}, bfu_en, 1'b0);
        chk1({tag, "_wr_en"}, wr_en, 1'b0);
        chk1({tag, "_rd_bank"}, rd_bank, 1'b0);
        chk1({tag, "_wr_bank"}, wr_bank, 1'b0);
        chk1({tag, "_res_bank"}, res_bank, 1'b0);
        chk({tag, "_stage"}, 32'(stage), 0);
        chk({tag, "_rd_addr_0"}, 32'(rd_addr_0), 0);
        chk({tag, "_rd_addr_1"}, 32'(rd_addr_1), 0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_wr_addr_0"}, 32'(wr_addr_0), 0);
        chk({tag, "_wr_addr_1"}, 32'(wr_addr_1), 0);
    endtask

    task automatic run3(input bit inv, input bit stall, input int start_t, input int abort_t);
        int cnt, ri, bi, wi, done_t;
        mode  = inv;
        valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        cnt = 0;
        while (rd_en !== 1'b1 && cnt < 10) begin
            step();
            cnt++;
        end
        chk("first_read_latency", 32'(cnt), 2);
        if (cnt >= 10) return;
        done_t = stall ? 26 : 21;
        for (int t = 0; t <= done_t + 1; t++) begin
            if (t == abort_t) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                chk_all_zero("abort");
                return;
            end
            ri = ridx(t, stall);
            bi = ridx(t - 1, stall);
            wi = ridx(t - 3, stall);
            chk1("rd_en", rd_en, ri >= 0);
            if (ri >= 0) begin
                chk("rd_addr_0", 32'(rd_addr_0), inv ? i_a0[ri] : f_a0[ri]);
                chk("rd_addr_1", 32'(rd_addr_1), inv ? i_a1[ri] : f_a1[ri]);
                chk("rom_addr", 32'(rom_addr), inv ? i_rom[ri] : f_rom[ri]);
                chk("stage", 32'(stage), ri / 4);
                chk1("rd_bank", rd_bank, (ri / 4) % 2 == 1);
            end
            chk1("bfu_en", bfu_en, bi >= 0);
            chk1("wr_en", wr_en, wi >= 0);
            if (wi >= 0) begin
                chk("wr_addr_0", 32'(wr_addr_0), inv ? i_a0[wi] : f_a0[wi]);
                chk("wr_addr_1", 32'(wr_addr_1), inv ? i_a1[wi] : f_a1[wi]);
                chk1("wr_bank", wr_bank, (wi / 4) % 2 == 0);
            end
            chk1("done", done, t == done_t);
            chk1("busy", busy, t < done_t);
            if (t == done_t) chk1("res_bank", res_bank, 1'b1);
            valid = !(stall && t >= 8 && t <= 12);
            start = (t == start_t);
            step();
        end
        start = 1'b0;
        valid = 1'b1;
    endtask

    task automatic run8();
        int cnt, n7;
        bit re, be, we;
        mode_8  = 1'b0;
        valid_8 = 1'b1;
        start_8 = 1'b1;
        step();
        start_8 = 1'b0;
        cnt = 0;
        while (rd_en_8 !== 1'b1 && cnt < 10) begin
            step();
            cnt++;
        end
        chk("n8_first_read_latency", 32'(cnt), 2);
        if (cnt >= 10) return;
        n7 = 0;
        for (int t = 0; t <= 1065; t++) begin
            re = (t < 1064) && (t % 133 < 128);
            be = (t >= 2) && (t - 2 < 1064) && ((t - 2) % 133 < 128);
            we = (t >= 5) && (t - 5 < 1064) && ((t - 5) % 133 < 128);
            chk1("n8_rd_en", rd_en_8, re);
            chk1("n8_bfu_en", bfu_en_8, be);
            chk1("n8_wr_en", wr_en_8, we);
            chk1("n8_done", done_8, t == 1064);
            if (re && t / 133 == 7) begin
                n7++;
                chk("n8_s7_rom", 32'(rom_addr_8), 0);
                chk("n8_s7_rd_addr_0", 32'(rd_addr_0_8), 2 * (t % 133));
            end
            if (t == 0) begin
                chk("n8_t0_rd0", 32'(rd_addr_0_8), 0);
                chk("n8_t0_rd1", 32'(rd_addr_1_8), 128);
                chk1("n8_busy", busy_8, 1'b1);
            end
            if (t == 5) begin
                chk("n8_t5_wr0", 32'(wr_addr_0_8), 0);
                chk("n8_t5_wr1", 32'(wr_addr_1_8), 128);
                chk1("n8_t5_wr_bank", wr_bank_8, 1'b1);
            end
            if (t == 127) begin
                chk("n8_t127_rd0", 32'(rd_addr_0_8), 127);
                chk("n8_t127_rd1", 32'(rd_addr_1_8), 255);
                chk("n8_t127_rom", 32'(rom_addr_8), 127);
            end
            if (t == 133) begin
                chk("n8_t133_rd0", 32'(rd_addr_0_8), 0);
                chk("n8_t133_rd1", 32'(rd_addr_1_8), 64);
                chk("n8_t133_stage", 32'(stage_8), 1);
                chk1("n8_t133_rd_bank", rd_bank_8, 1'b1);
            end
            if (t == 931) chk("n8_t931_stage", 32'(stage_8), 7);
            if (t == 1064) chk1("n8_res_bank", res_bank_8, 1'b0);
            if (t == 1065) chk1("n8_busy_end", busy_8, 1'b0);
            step();
        end
        chk("n8_stage7_reads", 32'(n7), 128);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        valid   = 1'b0;
        start_8 = 1'b0;
        mode_8  = 1'b0;
        valid_8 = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        chk1("reset_n8_busy", busy_8, 1'b0);
        chk1("reset_n8_rd_en", rd_en_8, 1'b0);
        rst_n = 1'b1;
        step();

        run3(1'b0, 1'b0, 2, -1);     // forward, stray start in RUN
        step();
        run3(1'b1, 1'b0, -1, -1);    // inverse
        step();
        run3(1'b0, 1'b1, -1, -1);    // forward with 5-cycle valid drop in stage 1
        step();
        run3(1'b0, 1'b0, -1, 8);     // reset mid stage 1
        step();
        run3(1'b0, 1'b0, -1, -1);    // fresh run after reset
        step();
        run8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ntt_addrgen_p.md
Name: ntt_addrgen_p

Overview:
Parametrised next-generation NTT/INTT address generator for the radix-2 butterfly datapath. For every stage it issues the butterfly read-address pairs and the twiddle ROM address, then returns the same pairs as write addresses after the memory and butterfly-unit latency. Ping-pong memory sets alternate every stage. It adds over the previous generation:
- generic transform size
- forward/inverse mode
- configurable pipeline depth
- stage drain, valid-stall, busy/done status.

Parameters:
LOGN, 8, log2 of transform length N (N = 2^LOGN, N/2 butterflies per stage); legal 3..12
RD_LAT, 1, RAM/ROM read latency in cycles; legal 1..4
BFU_LAT, 2, butterfly-unit latency in cycles; legal 1..8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle launch pulse; honoured only in IDLE
mode  in  1  0 = forward NTT, 1 = inverse; sampled with start
valid  in  1  run-enable: input data resident / downstream ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the final write
stage  out  $clog2(LOGN)  current read stage index
rd_en  out  1  read strobe for both memory ports and the ROM
rd_bank  out  1  memory set being read (0/1)
rd_addr_0  out  LOGN  upper-leg read address
rd_addr_1  out  LOGN  lower-leg read address
rom_addr  out  LOGN  twiddle ROM address
bfu_en  out  1  butterfly operands valid
wr_en  out  1  write strobe for both ports of set ~rd_bank
wr_bank  out  1  memory set being written
wr_addr_0  out  LOGN  upper-leg write address
wr_addr_1  out  LOGN  lower-leg write address
res_bank  out  1  set holding the final result (LOGN mod 2); valid when done

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Applies on any clock edge with rst_n = 0, including mid-transform; no partial completion.
- Define P = RD_LAT + BFU_LAT.
- States: IDLE -> WAIT (on start) -> RUN (when valid) -> DRAIN (after last read of a stage).
  - From DRAIN: next RUN stage, or FIN after the last stage.
  - FIN -> IDLE, asserting done for 1 cycle.
- start while busy is ignored. start and valid together in IDLE: WAIT is still entered; RUN begins the next cycle.
- RUN, butterfly counter k = 0..N/2-1, advances only when valid = 1:
  - valid = 0: rd_en = 0 and k holds.
  - In-flight items keep moving through the pipeline regardless of valid.
- Address arithmetic per stage s (all widths LOGN, no overflow by construction), with offset o = k mod h and group g = k div h:
  - Forward: h = N >> (s+1); rom_addr = o << s.
  - Inverse: h = 1 << s; rom_addr = N/2 + o * (N >> (s+1)). The ROM holds forward twiddles in the lower half and inverse twiddles in the upper half.
  - Both modes: rd_addr_0 = g*2h + o; rd_addr_1 = rd_addr_0 + h.
- Bank selection:
  - rd_bank = stage[0]; wr_bank = ~rd_bank, constant through each stage and its drain.
  - First stage reads set 0.
- Pipeline:
  - bfu_en = rd_en delayed RD_LAT cycles.
  - wr_en, wr_addr_0, wr_addr_1 = rd_en and rd addresses delayed P cycles (shift register).
  - All address outputs are registered.
- DRAIN:
  - Holds for exactly P cycles after the last read of the stage.
  - The next stage's first read happens no earlier than the cycle after the previous stage's last write (no RAW hazard).
  - Stage length with valid held high: N/2 + P cycles. Total from first read to done: LOGN*(N/2+P) cycles.
- With valid high throughout, the final write is at relative cycle LOGN*(N/2+P)-1 and done is at the next cycle. busy falls together with done.
- When done pulses, res_bank = LOGN mod 2.

Decomposition:
- Shared package ntt_pkg:
  - state encoding (IDLE, WAIT, RUN, DRAIN, FIN)
  - MODE_FWD/MODE_INV constants
  - function computing the stage-counter width
- One sub-module, ntt_delay_line: parametrised depth × width register chain, synchronous active-low clear. Instantiated twice:
  - RD_LAT deep for bfu_en
  - P deep for {wr_en, wr_addr_0, wr_addr_1}

Test Plan:
- LOGN=3, RD_LAT=1, BFU_LAT=2, forward, valid held high:
  - stage 0: read pairs (0,4)(1,5)(2,6)(3,7), rom 0,1,2,3
  - stage 1: (0,2)(1,3)(4,6)(5,7), rom 0,2,0,2
  - stage 2: (0,1)(2,3)(4,5)(6,7), rom 0 ×4
  - rd_bank 0,1,0; done at relative cycle 21; res_bank = 1
- Same configuration, inverse:
  - stage 0: pairs (0,1)(2,3)(4,5)(6,7), rom 4 ×4
  - stage 2: pairs (0,4)..(3,7), rom 4,5,6,7
- Pipeline check: every wr_en with wr_addr equal to the rd_addr issued exactly 3 cycles earlier. bfu_en lags rd_en by 1. First stage-1 read lands 1 cycle after the last stage-0 write.
- Drop valid for 5 cycles mid stage 1:
  - rd_en low and k frozen for those 5 cycles; in-flight writes still complete.
  - Addresses resume at the frozen k; done delayed by exactly 5 cycles.
- Pulse start during RUN: ignored, no address restart. Assert rst_n = 0 for 1 cycle mid stage 1: all outputs 0 on the next edge, state IDLE, and a fresh start reproduces the first scenario exactly.
- LOGN=8, RD_LAT=2, BFU_LAT=3, forward: 128 reads per stage; stage 7 rom_addr = 0 throughout; done at relative cycle 8*(128+5) = 1064.
